// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: register map offsets,
// STAT/CTRL bit positions and the controller state encoding.
package uart_pkg;

   // Register offsets from the UART base address
   localparam logic [31:0] OFF_RXDT = 32'h0;
   localparam logic [31:0] OFF_TXDT = 32'h4;
   localparam logic [31:0] OFF_CTRL = 32'h8;
   localparam logic [31:0] OFF_STAT = 32'hc;

   // STAT register bits
   localparam int STAT_RX_DONE = 0;
   localparam int STAT_TX_BUSY = 1;

   // CTRL register bits
   localparam int CTRL_RX_EN = 0;
   localparam int CTRL_TX_EN = 1;

   // Bus-master controller states
   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_IDLE   = 3'd1,
      ST_CFG    = 3'd2,
      ST_POLL   = 3'd3,
      ST_WRITE  = 3'd4,
      ST_SETTLE = 3'd5
   } tx_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first asserted request strictly after
// last_grant, wrapping around, wins. Produces one-hot and encoded forms.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid
);

   int               pos;
   logic [IDX_W-1:0] sel;

   // Scan from last_grant+1 upward with wrap; the first hit takes the grant.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      pos         = 0;
      sel         = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         pos = (int'(last_grant) + k) % NUM_REQ;
         sel = IDX_W'(pos);
         if (!grant_valid && req[sel]) begin
            grant_valid = 1'b1;
            grant[sel]  = 1'b1;
            grant_idx   = sel;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one memory-mapped UART transmitter among NUM_REQ byte producers.
// Sole master on the UART register bus: writes CTRL after reset and on
// request, and for each granted byte polls STAT until the transmitter is idle
// before writing TXDT. All bus outputs decode from registered state.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int          NUM_REQ    = 2,
   parameter logic [31:0] BASE_ADDR  = 32'hffff0020,
   parameter logic [31:0] CTRL_INIT  = (32'd1 << CTRL_RX_EN) | (32'd1 << CTRL_TX_EN),
   parameter int          POLL_LIMIT = 65535
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 done_valid,
   output logic [2:0]           done_id,
   input  logic                 cfg_we,
   input  logic [31:0]          cfg_ctrl,
   output logic                 err_timeout,
   output logic                 busy,
   output logic                 mem_we,
   output logic [31:0]          mem_addr,
   output logic [31:0]          mem_wdata,
   input  logic [31:0]          mem_rdata
);

   localparam int          IDX_W     = $clog2(NUM_REQ);
   localparam int          CNT_W     = $clog2(POLL_LIMIT + 1);
   localparam logic [31:0] ADDR_TXDT = BASE_ADDR + OFF_TXDT;
   localparam logic [31:0] ADDR_CTRL = BASE_ADDR + OFF_CTRL;
   localparam logic [31:0] ADDR_STAT = BASE_ADDR + OFF_STAT;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(POLL_LIMIT);

   // Control state (reset)
   tx_state_e        state_q, state_d;
   logic [IDX_W-1:0] last_grant_q, last_grant_d;
   logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;
   logic             cfg_pend_q;
   logic             err_q;

   // Datapath captures (not reset; only consumed in states that wrote them)
   logic [7:0]       byte_q;
   logic [IDX_W-1:0] id_q;
   logic [31:0]      cfg_val_q;

   // Per-cycle decisions from the next-state logic
   logic             take_byte;
   logic             cfg_clr;
   logic             set_err;

   // Arbiter results
   logic [NUM_REQ-1:0] arb_grant;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_valid;
   logic [7:0]         win_byte;

   // Read-data bits and RX register not used on the transmit path
   logic unused_rdata;
   assign unused_rdata = ^{mem_rdata[31:STAT_TX_BUSY+1], mem_rdata[STAT_RX_DONE], OFF_RXDT};

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req         (req_valid),
      .last_grant  (last_grant_q),
      .grant       (arb_grant),
      .grant_idx   (arb_idx),
      .grant_valid (arb_valid)
   );

   assign win_byte    = req_data[{arb_idx, 3'b000} +: 8];
   assign err_timeout = err_q & ~rst;

   // Next-state and bus/handshake decode from the registered state.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      poll_cnt_d   = poll_cnt_q;
      take_byte    = 1'b0;
      cfg_clr      = 1'b0;
      set_err      = 1'b0;
      req_ready    = '0;
      done_valid   = 1'b0;
      done_id      = '0;
      mem_we       = 1'b0;
      mem_addr     = ADDR_STAT;
      mem_wdata    = '0;
      busy         = (state_q != ST_IDLE);

      case (state_q)
         ST_INIT: begin
            mem_we    = 1'b1;
            mem_addr  = ADDR_CTRL;
            mem_wdata = CTRL_INIT;
            state_d   = ST_IDLE;
         end
         ST_CFG: begin
            mem_we    = 1'b1;
            mem_addr  = ADDR_CTRL;
            mem_wdata = cfg_val_q;
            state_d   = ST_IDLE;
         end
         ST_IDLE: begin
            // A pending reconfiguration always goes ahead of new bytes
            if (cfg_pend_q) begin
               cfg_clr = 1'b1;
               state_d = ST_CFG;
            end else if (arb_valid) begin
               req_ready    = arb_grant;
               take_byte    = 1'b1;
               last_grant_d = arb_idx;
               state_d      = ST_POLL;
            end
         end
         ST_POLL: begin
            if (!mem_rdata[STAT_TX_BUSY]) begin
               state_d = ST_WRITE;
            end else if (poll_cnt_q == CNT_MAX) begin
               // Transmitter never went idle: abandon this byte
               set_err    = 1'b1;
               poll_cnt_d = '0;
               state_d    = ST_IDLE;
            end else begin
               poll_cnt_d = poll_cnt_q + 1'b1;
            end
         end
         ST_WRITE: begin
            mem_we     = 1'b1;
            mem_addr   = ADDR_TXDT;
            mem_wdata  = {24'b0, byte_q};
            poll_cnt_d = '0;
            state_d    = ST_SETTLE;
         end
         ST_SETTLE: begin
            // Quiet bus cycle lets the UART raise TX_BUSY before the next poll
            done_valid = 1'b1;
            done_id    = 3'(id_q);
            state_d    = ST_IDLE;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase

      // Hold every output at its idle value while reset is asserted
      if (rst) begin
         req_ready  = '0;
         done_valid = 1'b0;
         done_id    = '0;
         mem_we     = 1'b0;
         mem_addr   = ADDR_STAT;
         mem_wdata  = '0;
         busy       = 1'b0;
      end
   end

   // Control registers: reset to INIT with no pending work and error clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_INIT;
         last_grant_q <= IDX_W'(NUM_REQ - 1);
         poll_cnt_q   <= '0;
         cfg_pend_q   <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         poll_cnt_q   <= poll_cnt_d;
         // Entry to CFG consumes the request; a pulse on that same edge is
         // served by this CFG write since its value is captured alongside.
         cfg_pend_q   <= cfg_clr ? 1'b0 : (cfg_pend_q | cfg_we);
         err_q        <= err_q | set_err;
      end
   end

   // Capture the granted byte/id and the most recent CTRL value.
   always_ff @(posedge clk) begin
      if (take_byte) begin
         byte_q <= win_byte;
         id_q   <= arb_idx;
      end
      if (cfg_we) begin
         cfg_val_q <= cfg_ctrl;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a small UART STAT model.
module tb_uart_tx_arbiter;

   localparam int          N     = 3;
   localparam int          PL    = 24;
   localparam logic [31:0] BASE  = 32'hffff0020;
   localparam logic [31:0] A_TX  = BASE + 32'h4;
   localparam logic [31:0] A_CT  = BASE + 32'h8;
   localparam logic [31:0] A_ST  = BASE + 32'hc;
   localparam logic [31:0] CINIT = 32'h3;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic           done_valid;
   logic [2:0]     done_id;
   logic           cfg_we;
   logic [31:0]    cfg_ctrl;
   logic           err_timeout;
   logic           busy;
   logic           mem_we;
   logic [31:0]    mem_addr;
   logic [31:0]    mem_wdata;
   logic [31:0]    mem_rdata;

   // UART model: TX_BUSY forced by 'stuck' or held busy_len cycles after a TXDT write
   logic stuck;
   int   busy_len;
   int   tx_cnt;
   int   cyc;

   assign mem_rdata = {30'b0, (stuck || (tx_cnt != 0)), 1'b0};

   uart_tx_arbiter #(
      .NUM_REQ    (N),
      .BASE_ADDR  (BASE),
      .CTRL_INIT  (CINIT),
      .POLL_LIMIT (PL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .done_valid  (done_valid),
      .done_id     (done_id),
      .cfg_we      (cfg_we),
      .cfg_ctrl    (cfg_ctrl),
      .err_timeout (err_timeout),
      .busy        (busy),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (rst) tx_cnt <= 0;
      else if (mem_we && mem_addr == A_TX) tx_cnt <= busy_len;
      else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
   end

   // Scoreboard state
   typedef struct {
      int         id;
      logic [7:0] data;
      int         cyc;
   } byte_t;

   byte_t       byte_q[$];
   int          done_q[$];
   int          done_cyc_q[$];
   logic        cfg_pend_m;
   logic [31:0] cfg_val_m;
   int          model_last;
   int          exp_lat = -1;
   logic        prev_poll_ok;
   logic        prev_err;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Round-robin rule: first valid index after 'last', wrapping
   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   byte_t mon_b;
   int    mon_w;

   // Monitor: compares every DUT event against the scoreboard
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_mem_we", {63'b0, mem_we}, 64'd0);
         chk("rst_mem_addr", {32'b0, mem_addr}, {32'b0, A_ST});
         chk("rst_mem_wdata", {32'b0, mem_wdata}, 64'd0);
         chk("rst_req_ready", {61'b0, req_ready}, 64'd0);
         chk("rst_busy", {63'b0, busy}, 64'd0);
         chk("rst_done", {63'b0, done_valid}, 64'd0);
         chk("rst_err", {63'b0, err_timeout}, 64'd0);
         byte_q.delete();
         done_q.delete();
         done_cyc_q.delete();
         cfg_pend_m   = 1'b1;
         cfg_val_m    = CINIT;
         model_last   = N - 1;
         prev_poll_ok = 1'b0;
         prev_err     = 1'b0;
      end else begin
         // Grant: must follow round robin, only in IDLE, never ahead of a pending CTRL write
         if (req_ready != '0 || (!busy && req_valid != '0 && !cfg_pend_m)) begin
            mon_w = rr_pick(req_valid, model_last);
            chk("grant_onehot", {61'b0, req_ready},
                (mon_w >= 0) ? (64'd1 << mon_w) : 64'd0);
            if (req_ready != '0) begin
               chk("grant_busy", {63'b0, busy}, 64'd0);
               chk("grant_cfg_first", {63'b0, cfg_pend_m}, 64'd0);
            end
            if (mon_w >= 0) begin
               mon_b.id   = mon_w;
               mon_b.data = req_data[mon_w*8 +: 8];
               mon_b.cyc  = cyc;
               byte_q.push_back(mon_b);
               model_last = mon_w;
            end
         end
         // TXDT write: only right after a STAT poll saw the transmitter idle
         if (mem_we && mem_addr == A_TX) begin
            chk("txdt_after_idle_poll", {63'b0, prev_poll_ok}, 64'd1);
            chk("txdt_busy", {63'b0, busy}, 64'd1);
            if (byte_q.size() == 0) begin
               chk("txdt_unexpected", 64'd1, 64'd0);
            end else begin
               mon_b = byte_q.pop_front();
               chk("txdt_data", {32'b0, mem_wdata}, {56'b0, mon_b.data});
               if (exp_lat >= 0) chk("txdt_latency", 64'(cyc - mon_b.cyc), 64'(exp_lat));
               done_q.push_back(mon_b.id);
               done_cyc_q.push_back(cyc + 1);
            end
         end
         // CTRL write: matches the latest requested value, never mid-byte
         if (mem_we && mem_addr == A_CT) begin
            chk("ctrl_not_interleaved", 64'(byte_q.size() + done_q.size()), 64'd0);
            chk("ctrl_expected", {63'b0, cfg_pend_m}, 64'd1);
            chk("ctrl_data", {32'b0, mem_wdata}, {32'b0, cfg_val_m});
            cfg_pend_m = 1'b0;
         end
         // Done pulse: one cycle after the TXDT write, with the right id
         if (done_valid) begin
            if (done_q.size() == 0) begin
               chk("done_unexpected", 64'd1, 64'd0);
            end else begin
               chk("done_id", {61'b0, done_id}, 64'(done_q.pop_front()));
               chk("done_cycle", 64'(cyc), 64'(done_cyc_q.pop_front()));
            end
         end else if (done_cyc_q.size() > 0 && done_cyc_q[0] <= cyc) begin
            chk("done_missing", 64'd0, 64'd1);
            void'(done_q.pop_front());
            void'(done_cyc_q.pop_front());
         end
         // Timeout: drops the in-flight byte after POLL_LIMIT+1 busy polls
         if (err_timeout && !prev_err) begin
            if (byte_q.size() == 0) begin
               chk("timeout_unexpected", 64'd1, 64'd0);
            end else begin
               mon_b = byte_q.pop_front();
               chk("timeout_latency", 64'(cyc - mon_b.cyc), 64'(PL + 2));
            end
         end
         if (cfg_we) begin
            cfg_pend_m = 1'b1;
            cfg_val_m  = cfg_ctrl;
         end
         prev_err     = err_timeout;
         prev_poll_ok = !mem_we && mem_addr == A_ST && !mem_rdata[1] && busy;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int id, input logic [7:0] d);
      bit got;
      got = 1'b0;
      req_valid[id] = 1'b1;
      req_data[id*8 +: 8] = d;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (req_ready[id]) got = 1'b1;
      end
      tick();
      req_valid[id] = 1'b0;
      if (!got) chk("send_accept", 64'd0, 64'd1);
   endtask

   task automatic drain(input int lim);
      int i;
      for (i = 0; i < lim; i++) begin
         @(negedge clk);
         if (!busy && byte_q.size() == 0 && done_q.size() == 0 && !cfg_pend_m) break;
      end
      chk("drain", 64'(i < lim), 64'd1);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   logic [N-1:0] acc;
   int           g[4];
   int           n;
   bit           seen;

   initial begin
      rst = 1'b1; req_valid = '0; req_data = '0; cfg_we = 1'b0; cfg_ctrl = '0;
      stuck = 1'b0; busy_len = 0;
      repeat (3) tick();
      rst = 1'b0;

      // First cycle after release writes CTRL_INIT, then IDLE
      @(negedge clk);
      chk("init_we", {63'b0, mem_we}, 64'd1);
      chk("init_addr", {32'b0, mem_addr}, 64'hffff0028);
      chk("init_wdata", {32'b0, mem_wdata}, 64'h3);
      @(negedge clk);
      chk("idle_after_init", {63'b0, busy}, 64'd0);
      tick();

      // Single byte, UART idle: minimum latency
      exp_lat = 2;
      send(0, 8'h41);
      drain(50);

      // Two requesters held valid: grants alternate
      req_data[7:0] = 8'h55; req_data[15:8] = 8'hAA;
      req_valid[0] = 1'b1; req_valid[1] = 1'b1;
      n = 0;
      for (int i = 0; i < 100 && n < 4; i++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            g[n] = req_ready[1] ? 1 : 0;
            n++;
         end
      end
      tick();
      req_valid = '0;
      chk("alt_count", 64'(n), 64'd4);
      for (int k = 1; k < 4; k++) chk("alt_toggle", 64'(g[k] != g[k-1]), 64'd1);
      drain(50);

      // STAT busy for 20 polls, then write on first idle poll
      exp_lat = 22;
      stuck = 1'b1;
      send(1, 8'h5a);
      repeat (20) @(posedge clk);
      #1 stuck = 1'b0;
      drain(100);

      // CTRL request during POLL: byte completes first, then CTRL, then next grant
      exp_lat = -1;
      stuck = 1'b1;
      send(0, 8'h11);
      cfg_ctrl = 32'h1; cfg_we = 1'b1;
      tick();
      cfg_we = 1'b0;
      repeat (3) tick();
      stuck = 1'b0;
      send(1, 8'h22);
      drain(100);

      // Poll timeout: error set, byte dropped, next byte still accepted
      chk("err_before_timeout", {63'b0, err_timeout}, 64'd0);
      stuck = 1'b1;
      send(2, 8'h99);
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (err_timeout) seen = 1'b1;
      end
      chk("timeout_seen", {63'b0, seen}, 64'd1);
      tick();
      stuck = 1'b0;
      send(0, 8'h42);
      drain(100);
      chk("err_sticky", {63'b0, err_timeout}, 64'd1);

      // Random traffic with random transmitter busy time and occasional CTRL writes
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         acc = req_valid & req_ready;
         tick();
         busy_len = $urandom_range(0, 4);
         cfg_we   = ($urandom_range(0, 40) == 0);
         cfg_ctrl = $urandom;
         for (int i = 0; i < N; i++) begin
            if (acc[i] || !req_valid[i]) begin
               req_valid[i]       = ($urandom_range(0, 2) != 0);
               req_data[i*8 +: 8] = 8'($urandom);
            end
         end
      end
      req_valid = '0; cfg_we = 1'b0;
      drain(300);
      busy_len = 0;
      repeat (6) tick();

      // Reset during POLL: no done pulse, INIT write repeats, error cleared
      chk("err_before_reset", {63'b0, err_timeout}, 64'd1);
      stuck = 1'b1;
      send(2, 8'h77);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      stuck = 1'b0;
      @(negedge clk);
      chk("reinit_we", {63'b0, mem_we}, 64'd1);
      chk("err_cleared", {63'b0, err_timeout}, 64'd0);
      drain(50);
      repeat (10) tick();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
